// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the user-control logic and led_pattern_sequencer.
// master = control side (drives requests), slave = sequencer (drives LED/status).
interface led_pattern_sequencer_if #(
    parameter int NUM_LED = 26
);
    localparam int SW = $clog2(2 * NUM_LED);

    logic               en;
    logic               pause;
    logic               mode_req;
    logic [1:0]         mode_sel;
    logic [NUM_LED-1:0] out;
    logic [1:0]         mode_cur;
    logic               pending;
    logic [SW-1:0]      step;
    logic               cycle_done;

    modport master (
        output en, pause, mode_req, mode_sel,
        input  out, mode_cur, pending, step, cycle_done
    );

    modport slave (
        input  en, pause, mode_req, mode_sel,
        output out, mode_cur, pending, step, cycle_done
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: four patterns paced by a prescaler, mode changes applied at cycle boundaries.
// Optional macro AUTO_CYCLE_EN: with no queued request, advance mode_cur by one at each boundary.
module led_pattern_sequencer #(
    parameter int NUM_LED  = 26,
    parameter int TICK_DIV = 1,
    parameter int MODE_RST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    led_pattern_sequencer_if.slave bus
);
    localparam int SW = $clog2(2 * NUM_LED);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0]      TICK_MAX    = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0]      STEP_N      = SW'(NUM_LED);
    localparam logic [SW-1:0]      LAST_RUN    = SW'(NUM_LED - 1);
    localparam logic [SW-1:0]      LAST_BOUNCE = SW'(2 * NUM_LED - 3);
    localparam logic [SW-1:0]      LAST_FILL   = SW'(NUM_LED);
    localparam logic [SW-1:0]      LAST_BLINK  = SW'(1);
    localparam logic [SW-1:0]      BOUNCE_TURN = SW'(2 * NUM_LED - 2);
    localparam logic [NUM_LED-1:0] ONE_HOT0    = {{(NUM_LED - 1){1'b0}}, 1'b1};
    localparam logic [NUM_LED-1:0] ALL_ONES    = {NUM_LED{1'b1}};
    localparam logic [NUM_LED-1:0] ALL_ZEROS   = {NUM_LED{1'b0}};

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam mode_t MODE_RST_V = mode_t'(2'(MODE_RST));

    function automatic logic [SW-1:0] last_step(input mode_t m);
        logic [SW-1:0] l;
        case (m)
            MODE_RUN:    l = LAST_RUN;
            MODE_BOUNCE: l = LAST_BOUNCE;
            MODE_FILL:   l = LAST_FILL;
            MODE_BLINK:  l = LAST_BLINK;
            default:     l = LAST_RUN;
        endcase
        return l;
    endfunction

    // Bounce folds the second half of the step range back onto positions N-2..1.
    function automatic logic [NUM_LED-1:0] pattern(input mode_t m, input logic [SW-1:0] s);
        logic [NUM_LED-1:0] p;
        logic [SW-1:0]      pos;
        pos = (s < STEP_N) ? s : (BOUNCE_TURN - s);
        case (m)
            MODE_RUN:    p = ONE_HOT0 << s;
            MODE_BOUNCE: p = ONE_HOT0 << pos;
            MODE_FILL:   p = (s < STEP_N) ? ~(ALL_ONES << (s + SW'(1))) : ALL_ZEROS;
            MODE_BLINK:  p = (s == {SW{1'b0}}) ? ALL_ONES : ALL_ZEROS;
            default:     p = ALL_ZEROS;
        endcase
        return p;
    endfunction

    logic [CW-1:0]      presc_r, presc_s;
    logic [SW-1:0]      step_r, step_s;
    logic [NUM_LED-1:0] out_r, out_s;
    mode_t              mode_r, mode_s;
    mode_t              queue_r, queue_s;
    logic               pend_r, pend_s;
    logic               done_r, done_s;
    logic               tick_s;
    logic               boundary_s;

    // Next-state: prescaler/step advance, pattern generation and mode-queue arbitration.
    always_comb begin
        presc_s    = presc_r;
        step_s     = step_r;
        out_s      = out_r;
        mode_s     = mode_r;
        queue_s    = queue_r;
        pend_s     = pend_r;
        done_s     = 1'b0;
        tick_s     = 1'b0;
        boundary_s = 1'b0;

        if (!bus.en) begin
            presc_s = {CW{1'b0}};
            step_s  = {SW{1'b0}};
            out_s   = ALL_ZEROS;
        end else if (bus.pause) begin
            presc_s = presc_r;
        end else begin
            tick_s = (presc_r == TICK_MAX);
            if (tick_s) begin
                presc_s = {CW{1'b0}};
                out_s   = pattern(mode_r, step_r);
                if (step_r == last_step(mode_r)) begin
                    boundary_s = 1'b1;
                    done_s     = 1'b1;
                    step_s     = {SW{1'b0}};
                end else begin
                    step_s = step_r + SW'(1);
                end
            end else begin
                presc_s = presc_r + CW'(1);
            end
        end

        // A request arriving on the boundary tick itself wins over anything already queued.
        if (boundary_s) begin
            pend_s = 1'b0;
            if (bus.mode_req) begin
                mode_s  = mode_t'(bus.mode_sel);
                queue_s = mode_t'(bus.mode_sel);
            end else if (pend_r) begin
                mode_s = queue_r;
            end else begin
`ifdef AUTO_CYCLE_EN
                mode_s = mode_t'(mode_r + 2'd1);
`else
                mode_s = mode_r;
`endif
            end
        end else if (bus.mode_req) begin
            queue_s = mode_t'(bus.mode_sel);
            pend_s  = 1'b1;
        end else begin
            pend_s = pend_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {CW{1'b0}};
            step_r  <= {SW{1'b0}};
            out_r   <= ALL_ZEROS;
            mode_r  <= MODE_RST_V;
            queue_r <= MODE_RUN;
            pend_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            presc_r <= presc_s;
            step_r  <= step_s;
            out_r   <= out_s;
            mode_r  <= mode_s;
            queue_r <= queue_s;
            pend_r  <= pend_s;
            done_r  <= done_s;
        end
    end

    assign bus.out        = out_r;
    assign bus.mode_cur   = mode_r;
    assign bus.pending    = pend_r;
    assign bus.step       = step_r;
    assign bus.cycle_done = done_r;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: a list-based reference model predicts every
// registered output per clock; a monitor pops and compares after each rising edge.
module tb_led_pattern_sequencer;
    localparam int N  = 26;
    localparam int TD = 2;
    localparam int SW = $clog2(2 * N);

    typedef struct {
        logic [N-1:0]  out;
        logic [SW-1:0] step;
        logic [1:0]    mode;
        logic          pend;
        logic          done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [N-1:0] seq_run[$];
    logic [N-1:0] seq_bnc[$];
    logic [N-1:0] seq_fill[$];
    logic [N-1:0] seq_blk[$];

    // reference model state (values the DUT registers hold after the next edge)
    logic [N-1:0] m_out;
    int           m_idx, m_cnt, m_mode, m_queue;
    bit           m_pend, m_done;

    led_pattern_sequencer_if #(.NUM_LED(N)) bus ();

    led_pattern_sequencer #(.NUM_LED(N), .TICK_DIV(TD), .MODE_RST(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int plen(input int m);
        case (m)
            0:       return seq_run.size();
            1:       return seq_bnc.size();
            2:       return seq_fill.size();
            default: return seq_blk.size();
        endcase
    endfunction

    function automatic logic [N-1:0] pat(input int m, input int i);
        case (m)
            0:       return seq_run[i];
            1:       return seq_bnc[i];
            2:       return seq_fill[i];
            default: return seq_blk[i];
        endcase
    endfunction

    task automatic build_seqs();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v = '0; v[i] = 1'b1;
            seq_run.push_back(v);
            seq_bnc.push_back(v);
        end
        for (int i = N - 2; i >= 1; i--) begin
            v = '0; v[i] = 1'b1;
            seq_bnc.push_back(v);
        end
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1;
            seq_fill.push_back(v);
        end
        seq_fill.push_back('0);
        seq_blk.push_back('1);
        seq_blk.push_back('0);
    endtask

    task automatic model_step(input bit r, input bit e, input bit p, input bit q, input int s);
        bit boundary;
        boundary = 1'b0;
        if (r) begin
            m_out = '0; m_idx = 0; m_cnt = 0; m_mode = 0; m_queue = 0; m_pend = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!e) begin
                m_out = '0; m_idx = 0; m_cnt = 0;
            end else if (!p) begin
                m_cnt++;
                if (m_cnt == TD) begin
                    m_cnt = 0;
                    m_out = pat(m_mode, m_idx);
                    if (m_idx == plen(m_mode) - 1) begin
                        boundary = 1'b1; m_done = 1'b1; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (boundary) begin
                if (q) begin
                    m_mode = s; m_queue = s;
                end else if (m_pend) begin
                    m_mode = m_queue;
                end else begin
`ifdef AUTO_CYCLE_EN
                    m_mode = (m_mode + 1) % 4;
`endif
                end
                m_pend = 1'b0;
            end else if (q) begin
                m_queue = s; m_pend = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit p, input bit q, input int s);
        exp_t x;
        @(negedge clk);
        rst          = r;
        bus.en       = e;
        bus.pause    = p;
        bus.mode_req = q;
        bus.mode_sel = 2'(s);
        model_step(r, e, p, q, s);
        x.out  = m_out;
        x.step = SW'(m_idx);
        x.mode = 2'(m_mode);
        x.pend = m_pend;
        x.done = m_done;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: every registered output is compared once per clock, after the edge settles.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("out",        64'(bus.out),        64'(mon_e.out));
            check("step",       64'(bus.step),       64'(mon_e.step));
            check("mode_cur",   64'(bus.mode_cur),   64'(mon_e.mode));
            check("pending",    64'(bus.pending),    64'(mon_e.pend));
            check("cycle_done", 64'(bus.cycle_done), 64'(mon_e.done));
        end
    end

    initial begin
        bit cur_en, cur_pause, r, q, near;
        bus.en = 1'b0; bus.pause = 1'b0; bus.mode_req = 1'b0; bus.mode_sel = 2'd0;
        build_seqs();

        // Directed walk through the main scenarios.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 1);
        for (int i = 0; i < 130; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 2);
        for (int i = 0; i < 150; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 3);
        for (int i = 0; i < 70; i++) drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 2);
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0);

        // Randomized phase, biased so requests often land exactly on boundary ticks.
        cur_en = 1'b1; cur_pause = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            r = ($urandom_range(0, 999) == 0);
            if (cur_en) cur_en = ($urandom_range(0, 199) != 0);
            else        cur_en = ($urandom_range(0, 7) == 0);
            if (cur_pause) cur_pause = ($urandom_range(0, 5) != 0);
            else           cur_pause = ($urandom_range(0, 149) == 0);
            near = cur_en && !cur_pause && (m_cnt == TD - 1) && (m_idx == plen(m_mode) - 1);
            q = ($urandom_range(0, 59) == 0) || (near && ($urandom_range(0, 1) == 1));
            drive(r, cur_en, cur_pause, q, int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
